otter_hazard_unit: RTL and testbench

//  Hazard/control unit for the 5-stage OTTER pipeline (FE, DE, EX, MEM, WB).

---
 rtl/otter_hazard_unit.sv | 157 +++++++++++++++
 tb/tb_otter_hazard_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/otter_hazard_unit.sv
// Hazard/control unit for the 5-stage OTTER pipeline: forwarding selects, load-use bubbles, branch flushes.
// Define HAZARD_PERF_CNT_EN to add the saturating STALL_CNT/FLUSH_CNT performance counters.
module otter_hazard_unit #(
    parameter int RA_W             = 5,
    parameter int LOAD_USE_BUBBLES = 1
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W          = 32
`endif
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [RA_W-1:0] DE_RS1,
    input  logic [RA_W-1:0] DE_RS2,
    input  logic            DE_USES_RS1,
    input  logic            DE_USES_RS2,
    input  logic [RA_W-1:0] DE_RD,
    input  logic            DE_REG_WRITE,
    input  logic            DE_MEM_READ,
    input  logic            EX_BR_TAKEN,
    output logic            PC_EN,
    output logic            FE_DE_EN,
    output logic            FE_DE_FLUSH,
    output logic            DE_EX_FLUSH,
    output logic [1:0]      FWD_A_SEL,
    output logic [1:0]      FWD_B_SEL,
    output logic            STALL
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

    typedef enum logic {
        S_RUN,
        S_STALL
    } state_t;

    localparam logic [1:0] BUBBLE_CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

    state_t          state, state_next;
    logic [1:0]      cnt, cnt_next;
    logic            stall;

    // WB entry is not kept: the register file is write-through, so it never needs a compare.
    logic            ex_valid, ex_reg_write, ex_mem_read;
    logic [RA_W-1:0] ex_rd;
    logic            mem_valid, mem_reg_write;
    logic [RA_W-1:0] mem_rd;

    logic            ex_prod, mem_prod;
    logic            ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic            load_use;
    logic [1:0]      fwd_a_next, fwd_b_next;

    assign ex_prod   = ex_valid  & ex_reg_write  & (ex_rd  != '0);
    assign mem_prod  = mem_valid & mem_reg_write & (mem_rd != '0);
    assign ex_hit_a  = ex_prod  & (DE_RS1 == ex_rd);
    assign ex_hit_b  = ex_prod  & (DE_RS2 == ex_rd);
    assign mem_hit_a = mem_prod & (DE_RS1 == mem_rd);
    assign mem_hit_b = mem_prod & (DE_RS2 == mem_rd);
    assign load_use  = ex_mem_read & ((DE_USES_RS1 & ex_hit_a) | (DE_USES_RS2 & ex_hit_b));

    assign fwd_a_next = ex_hit_a ? 2'd1 : (mem_hit_a ? 2'd2 : 2'd0);
    assign fwd_b_next = ex_hit_b ? 2'd1 : (mem_hit_b ? 2'd2 : 2'd0);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        if (EX_BR_TAKEN) begin
            state_next = S_RUN;
            cnt_next   = '0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (load_use) begin
                        stall = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_next = S_STALL;
                            cnt_next   = BUBBLE_CNT_INIT;
                        end
                    end
                end
                S_STALL: begin
                    stall    = 1'b1;
                    cnt_next = cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        state_next = S_RUN;
                        cnt_next   = '0;
                    end
                end
                default: state_next = S_RUN;
            endcase
        end
    end

    always_comb begin
        PC_EN       = ~stall;
        FE_DE_EN    = ~stall;
        FE_DE_FLUSH = EX_BR_TAKEN;
        DE_EX_FLUSH = stall | EX_BR_TAKEN;
        STALL       = stall;
        if (RST) begin
            PC_EN       = 1'b0;
            FE_DE_EN    = 1'b0;
            FE_DE_FLUSH = 1'b1;
            DE_EX_FLUSH = 1'b1;
            STALL       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_RUN;
            cnt           <= '0;
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            FWD_A_SEL     <= 2'd0;
            FWD_B_SEL     <= 2'd0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            ex_valid      <= ~DE_EX_FLUSH;
            ex_rd         <= DE_RD;
            ex_reg_write  <= DE_REG_WRITE;
            ex_mem_read   <= DE_MEM_READ;
            FWD_A_SEL     <= DE_EX_FLUSH ? 2'd0 : fwd_a_next;
            FWD_B_SEL     <= DE_EX_FLUSH ? 2'd0 : fwd_b_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (stall && (STALL_CNT != '1))
                STALL_CNT <= STALL_CNT + 1'b1;
            if (EX_BR_TAKEN && (FLUSH_CNT != '1))
                FLUSH_CNT <= FLUSH_CNT + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Directed bench for otter_hazard_unit: one instance with 1 load-use bubble, one with 2, sharing stimulus.
module tb_otter_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] de_rs1, de_rs2, de_rd;
    logic       de_uses_rs1, de_uses_rs2, de_reg_write, de_mem_read;
    logic       ex_br_taken;

    logic       pc_en_1, fe_de_en_1, fe_de_flush_1, de_ex_flush_1, stall_1;
    logic [1:0] fwd_a_1, fwd_b_1;
    logic       pc_en_2, fe_de_en_2, fe_de_flush_2, de_ex_flush_2, stall_2;
    logic [1:0] fwd_a_2, fwd_b_2;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_1, flush_cnt_1, stall_cnt_2, flush_cnt_2;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    otter_hazard_unit #(.RA_W(5), .LOAD_USE_BUBBLES(1)) dut1 (
        .CLK(clk), .RST(rst),
        .DE_RS1(de_rs1), .DE_RS2(de_rs2), .DE_USES_RS1(de_uses_rs1), .DE_USES_RS2(de_uses_rs2),
        .DE_RD(de_rd), .DE_REG_WRITE(de_reg_write), .DE_MEM_READ(de_mem_read),
        .EX_BR_TAKEN(ex_br_taken),
        .PC_EN(pc_en_1), .FE_DE_EN(fe_de_en_1), .FE_DE_FLUSH(fe_de_flush_1),
        .DE_EX_FLUSH(de_ex_flush_1), .FWD_A_SEL(fwd_a_1), .FWD_B_SEL(fwd_b_1), .STALL(stall_1)
`ifdef HAZARD_PERF_CNT_EN
        , .STALL_CNT(stall_cnt_1), .FLUSH_CNT(flush_cnt_1)
`endif
    );

    otter_hazard_unit #(.RA_W(5), .LOAD_USE_BUBBLES(2)) dut2 (
        .CLK(clk), .RST(rst),
        .DE_RS1(de_rs1), .DE_RS2(de_rs2), .DE_USES_RS1(de_uses_rs1), .DE_USES_RS2(de_uses_rs2),
        .DE_RD(de_rd), .DE_REG_WRITE(de_reg_write), .DE_MEM_READ(de_mem_read),
        .EX_BR_TAKEN(ex_br_taken),
        .PC_EN(pc_en_2), .FE_DE_EN(fe_de_en_2), .FE_DE_FLUSH(fe_de_flush_2),
        .DE_EX_FLUSH(de_ex_flush_2), .FWD_A_SEL(fwd_a_2), .FWD_B_SEL(fwd_b_2), .STALL(stall_2)
`ifdef HAZARD_PERF_CNT_EN
        , .STALL_CNT(stall_cnt_2), .FLUSH_CNT(flush_cnt_2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic mr);
        de_rs1       = rs1;
        de_rs2       = rs2;
        de_uses_rs1  = u1;
        de_uses_rs2  = u2;
        de_rd        = rd;
        de_reg_write = rw;
        de_mem_read  = mr;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic lw_x5();
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    endtask

    task automatic add_x6_x5_x0();
        drive(5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        ex_br_taken = 1'b0;
        nop();
        #3;
        check("rst_pc_en",       32'(pc_en_1),       32'd0);
        check("rst_fe_de_en",    32'(fe_de_en_1),    32'd0);
        check("rst_fe_de_flush", 32'(fe_de_flush_1), 32'd1);
        check("rst_de_ex_flush", 32'(de_ex_flush_1), 32'd1);
        check("rst_stall",       32'(stall_2),       32'd0);
        check("rst_fwd_a",       32'(fwd_a_1),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_pc_en", 32'(pc_en_1), 32'd1);
        check("post_rst_stall", 32'(stall_1), 32'd0);
        cycle();

        // addi x5 ; add x6,x5,x5
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); cycle();
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
        check("t1_stall", 32'(stall_1), 32'd0);
        check("t1_pc_en", 32'(pc_en_1), 32'd1);
        cycle();
        nop(); #1;
        check("t1_fwd_a", 32'(fwd_a_1), 32'd1);
        check("t1_fwd_b", 32'(fwd_b_1), 32'd1);

        // addi x5 ; nop ; sub x7,x5,x1
        cycle();
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); cycle();
        nop(); cycle();
        drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); cycle();
        nop(); #1;
        check("t2_fwd_a", 32'(fwd_a_1), 32'd2);
        check("t2_fwd_b", 32'(fwd_b_1), 32'd0);
        cycle(); nop(); cycle();

        // lw x5 ; add x6,x5,x0 with 1 and 2 bubbles
        lw_x5(); cycle();
        add_x6_x5_x0(); #1;
        check("t3_s0_stall_1",       32'(stall_1),       32'd1);
        check("t3_s0_stall_2",       32'(stall_2),       32'd1);
        check("t3_s0_pc_en_1",       32'(pc_en_1),       32'd0);
        check("t3_s0_fe_de_en_1",    32'(fe_de_en_1),    32'd0);
        check("t3_s0_de_ex_flush_1", 32'(de_ex_flush_1), 32'd1);
        check("t3_s0_fe_de_flush_1", 32'(fe_de_flush_1), 32'd0);
        cycle();
        add_x6_x5_x0(); #1;
        check("t3_s1_stall_1", 32'(stall_1), 32'd0);
        check("t3_s1_pc_en_1", 32'(pc_en_1), 32'd1);
        check("t3_s1_stall_2", 32'(stall_2), 32'd1);
        check("t3_s1_pc_en_2", 32'(pc_en_2), 32'd0);
        cycle();
        add_x6_x5_x0(); #1;
        check("t3_fwd_a_1",    32'(fwd_a_1), 32'd2);
        check("t3_fwd_b_1",    32'(fwd_b_1), 32'd0);
        check("t3_s2_stall_2", 32'(stall_2), 32'd0);
        check("t3_s2_pc_en_2", 32'(pc_en_2), 32'd1);
        cycle();
        nop(); #1;
        check("t3_fwd_a_2", 32'(fwd_a_2), 32'd0);
        check("t3_fwd_b_2", 32'(fwd_b_2), 32'd0);
        cycle(); nop(); cycle(); cycle();

        // Load already in MEM: no stall, forwarded from MEM_WB
        lw_x5(); cycle();
        nop(); cycle();
        add_x6_x5_x0(); #1;
        check("mem_load_stall_1", 32'(stall_1), 32'd0);
        cycle();
        nop(); #1;
        check("mem_load_fwd_a_1", 32'(fwd_a_1), 32'd2);
        cycle(); cycle();

        // Load in EX but DE does not read its rs fields
        lw_x5(); cycle();
        drive(5'd5, 5'd5, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0); #1;
        check("unused_rs_stall_1", 32'(stall_1), 32'd0);
        check("unused_rs_stall_2", 32'(stall_2), 32'd0);
        cycle(); nop(); cycle(); cycle();

        // addi x0,x0,1 ; add x6,x0,x0
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0); cycle();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); cycle();
        nop(); #1;
        check("t5_fwd_a", 32'(fwd_a_1), 32'd0);
        check("t5_fwd_b", 32'(fwd_b_1), 32'd0);
        cycle(); cycle();

        // Branch taken beats load-use
        lw_x5(); cycle();
        add_x6_x5_x0();
        ex_br_taken = 1'b1;
        #1;
        check("t4_stall_1",       32'(stall_1),       32'd0);
        check("t4_stall_2",       32'(stall_2),       32'd0);
        check("t4_fe_de_flush_2", 32'(fe_de_flush_2), 32'd1);
        check("t4_de_ex_flush_2", 32'(de_ex_flush_2), 32'd1);
        check("t4_pc_en_2",       32'(pc_en_2),       32'd1);
        check("t4_fe_de_en_2",    32'(fe_de_en_2),    32'd1);
        cycle();
        ex_br_taken = 1'b0;
        nop(); #1;
        check("t4_after_stall_2", 32'(stall_2), 32'd0);
        check("t4_after_pc_en_2", 32'(pc_en_2), 32'd1);
        check("t4_after_fwd_a_2", 32'(fwd_a_2), 32'd0);
        check("t4_after_flush_2", 32'(fe_de_flush_2), 32'd0);
        cycle(); cycle();

        // Reset during the second bubble of a 2-bubble stall
        lw_x5(); cycle();
        add_x6_x5_x0(); #1;
        check("t6_s0_stall_2", 32'(stall_2), 32'd1);
        cycle();
        add_x6_x5_x0(); #1;
        check("t6_s1_stall_2", 32'(stall_2), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_pc_en_2",       32'(pc_en_2),       32'd0);
        check("t6_rst_fe_de_en_2",    32'(fe_de_en_2),    32'd0);
        check("t6_rst_fe_de_flush_2", 32'(fe_de_flush_2), 32'd1);
        check("t6_rst_de_ex_flush_2", 32'(de_ex_flush_2), 32'd1);
        check("t6_rst_stall_2",       32'(stall_2),       32'd0);
        cycle();
        @(negedge clk);
        rst = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        check("t6_rel_pc_en_2", 32'(pc_en_2), 32'd1);
        check("t6_rel_stall_2", 32'(stall_2), 32'd0);
        check("t6_rel_stall_1", 32'(stall_1), 32'd0);
        check("t6_rel_fwd_a_2", 32'(fwd_a_2), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("t6_rel_stall_cnt_2", stall_cnt_2, 32'd0);
        check("t6_rel_flush_cnt_2", flush_cnt_2, 32'd0);
`endif
        cycle();
        nop(); #1;
        check("t6_after_fwd_a_2", 32'(fwd_a_2), 32'd0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
